// File: rtl/ahb_slv2mst_reg_bridge.sv
// Registered AHB-Lite bridge from a mirrored-slave port to a mirrored-master port.
// It carries one transfer at a time and cuts every path between the two sides.
// Upstream bursts are flattened into NONSEQ/SINGLE transfers, and the upper
// address bits can optionally be remapped.
// Downstream ERROR responses are passed back upstream as a two-cycle ERROR
// response.
// An optional timeout aborts a downstream transfer that stalls too long.
//
// Handshake: a request is accepted when HSEL_SLAVE & HREADY_SLAVE & HTRANS_SLAVE[1]
// is high in IDLE or RESP.
// Downstream, the address phase is held while HREADY_MASTER is low, and the data
// phase completes when HREADY_MASTER is high.
// DBG_STATE shows the FSM state (0 IDLE, 1 ADDR, 2 DATA, 3 RESP, 4 ERR1, 5 ERR2).
module ahb_slv2mst_reg_bridge #(
   parameter int                    ADDR_WIDTH     = 32,
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    REMAP_EN       = 0,
   parameter int                    REMAP_BITS     = 4,
   parameter logic [REMAP_BITS-1:0] REMAP_VALUE    = '0,
   parameter int                    TIMEOUT_CYCLES = 0
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   // upstream request
   input  logic                  HSEL_SLAVE,
   input  logic [ADDR_WIDTH-1:0] HADDR_SLAVE,
   input  logic [1:0]            HTRANS_SLAVE,
   input  logic [2:0]            HSIZE_SLAVE,
   input  logic [2:0]            HBURST_SLAVE,
   input  logic [3:0]            HPROT_SLAVE,
   input  logic                  HWRITE_SLAVE,
   input  logic                  HMASTLOCK_SLAVE,
   input  logic [DATA_WIDTH-1:0] HWDATA_SLAVE,
   input  logic                  HREADY_SLAVE,
   // upstream response
   output logic                  HREADYOUT_SLAVE,
   output logic [DATA_WIDTH-1:0] HRDATA_SLAVE,
   output logic [1:0]            HRESP_SLAVE,
   // downstream request
   output logic [ADDR_WIDTH-1:0] HADDR_MASTER,
   output logic [1:0]            HTRANS_MASTER,
   output logic [2:0]            HSIZE_MASTER,
   output logic [2:0]            HBURST_MASTER,
   output logic [3:0]            HPROT_MASTER,
   output logic                  HWRITE_MASTER,
   output logic                  HMASTLOCK_MASTER,
   output logic [DATA_WIDTH-1:0] HWDATA_MASTER,
   // downstream response
   input  logic                  HREADY_MASTER,
   input  logic [DATA_WIDTH-1:0] HRDATA_MASTER,
   input  logic [1:0]            HRESP_MASTER,
   // status and debug
   output logic                  TIMEOUT_FLAG,
   output logic [2:0]            DBG_STATE
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_DATA = 3'd2,
      S_RESP = 3'd3,
      S_ERR1 = 3'd4,
      S_ERR2 = 3'd5
   } state_t;

   localparam logic [1:0]  TRANS_IDLE   = 2'b00;
   localparam logic [1:0]  TRANS_NONSEQ = 2'b10;
   localparam logic [1:0]  RESP_OKAY    = 2'b00;
   localparam logic [1:0]  RESP_ERROR   = 2'b01;
   localparam logic [15:0] TO_LIMIT     = 16'(TIMEOUT_CYCLES);
   localparam bit          TO_EN        = (TIMEOUT_CYCLES != 0);

   state_t                state_q, state_d;
   logic [15:0]           cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [2:0]            size_q, size_d;
   logic [3:0]            prot_q, prot_d;
   logic                  write_q, write_d;
   logic                  lock_q, lock_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  hreadyout_q, hreadyout_d;
   logic [1:0]            hresp_q, hresp_d;
   logic [1:0]            htrans_q, htrans_d;
   logic                  flag_q, flag_d;

   logic                  req_valid;
   logic                  can_accept;
   logic                  capture;
   logic                  busy;
   logic                  timeout_hit;
   logic [15:0]           cnt_inc;
   logic [ADDR_WIDTH-1:0] addr_in;
   logic                  unused_inputs;

   // Address as it will appear downstream.
   generate
      if (REMAP_EN != 0) begin : g_remap
         logic [REMAP_BITS-1:0] unused_upper;
         assign addr_in      = {REMAP_VALUE, HADDR_SLAVE[ADDR_WIDTH-REMAP_BITS-1:0]};
         assign unused_upper = HADDR_SLAVE[ADDR_WIDTH-1:ADDR_WIDTH-REMAP_BITS];
      end else begin : g_no_remap
         assign addr_in = HADDR_SLAVE;
      end
   endgenerate

   // The burst type is deliberately dropped. Only HTRANS[1] matters, and only
   // HRESP[0] (OKAY or ERROR) can occur on an AHB-Lite response.
   assign unused_inputs = ^{HBURST_SLAVE, HTRANS_SLAVE[0], HRESP_MASTER[1]};

   // The counter holds the number of cycles already spent in ADDR/DATA, so it
   // reaches the limit on the TIMEOUT_CYCLES-th cycle.
   assign req_valid   = HSEL_SLAVE & HREADY_SLAVE & HTRANS_SLAVE[1];
   assign can_accept  = (state_q == S_IDLE) || (state_q == S_RESP);
   assign capture     = req_valid & can_accept;
   assign busy        = (state_q == S_ADDR) || (state_q == S_DATA);
   assign cnt_inc     = cnt_q + 16'd1;
   assign timeout_hit = TO_EN && busy && (cnt_inc == TO_LIMIT);

   // State register.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. A timeout takes priority over a downstream completion
   // in the same cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) state_d = S_ADDR;
         end
         S_ADDR: begin
            if (timeout_hit)        state_d = S_ERR1;
            else if (HREADY_MASTER) state_d = S_DATA;
         end
         S_DATA: begin
            if (timeout_hit)          state_d = S_ERR1;
            else if (HRESP_MASTER[0]) state_d = S_ERR1;
            else if (HREADY_MASTER)   state_d = S_RESP;
         end
         S_RESP: begin
            state_d = req_valid ? S_ADDR : S_IDLE;
         end
         S_ERR1:  state_d = S_ERR2;
         S_ERR2:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Capture the request and the write data, run the timeout counter, and keep
   // the sticky flag.
   always_comb begin
      addr_d  = addr_q;
      size_d  = size_q;
      prot_d  = prot_q;
      write_d = write_q;
      lock_d  = lock_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      flag_d  = flag_q | timeout_hit;
      if (capture) begin
         addr_d  = addr_in;
         size_d  = HSIZE_SLAVE;
         prot_d  = HPROT_SLAVE;
         write_d = HWRITE_SLAVE;
         lock_d  = HMASTLOCK_SLAVE;
         cnt_d   = 16'd0;
      end else if (busy) begin
         cnt_d = cnt_inc;
      end
      // The first ADDR cycle is the upstream data phase. Upstream is stalled
      // from then on, so one sample is enough.
      if ((state_q == S_ADDR) && (cnt_q == 16'd0)) begin
         wdata_d = HWDATA_SLAVE;
      end
   end

   // Output decode from the upcoming state, so every output comes from a flop.
   always_comb begin
      hreadyout_d = 1'b1;
      hresp_d     = RESP_OKAY;
      htrans_d    = TRANS_IDLE;
      rdata_d     = '0;
      unique case (state_d)
         S_ADDR: begin
            hreadyout_d = 1'b0;
            htrans_d    = TRANS_NONSEQ;
         end
         S_DATA: begin
            hreadyout_d = 1'b0;
         end
         S_RESP: begin
            // RESP is only entered from a completing DATA cycle.
            rdata_d = HRDATA_MASTER;
         end
         S_ERR1: begin
            hreadyout_d = 1'b0;
            hresp_d     = RESP_ERROR;
         end
         S_ERR2: begin
            hresp_d = RESP_ERROR;
         end
         default: begin
            hreadyout_d = 1'b1;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         addr_q      <= '0;
         size_q      <= '0;
         prot_q      <= '0;
         write_q     <= 1'b0;
         lock_q      <= 1'b0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         cnt_q       <= '0;
         flag_q      <= 1'b0;
         hreadyout_q <= 1'b1;
         hresp_q     <= RESP_OKAY;
         htrans_q    <= TRANS_IDLE;
      end else begin
         addr_q      <= addr_d;
         size_q      <= size_d;
         prot_q      <= prot_d;
         write_q     <= write_d;
         lock_q      <= lock_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         cnt_q       <= cnt_d;
         flag_q      <= flag_d;
         hreadyout_q <= hreadyout_d;
         hresp_q     <= hresp_d;
         htrans_q    <= htrans_d;
      end
   end

   assign HREADYOUT_SLAVE  = hreadyout_q;
   assign HRDATA_SLAVE     = rdata_q;
   assign HRESP_SLAVE      = hresp_q;
   assign HADDR_MASTER     = addr_q;
   assign HTRANS_MASTER    = htrans_q;
   assign HSIZE_MASTER     = size_q;
   assign HBURST_MASTER    = 3'b000;
   assign HPROT_MASTER     = prot_q;
   assign HWRITE_MASTER    = write_q;
   assign HMASTLOCK_MASTER = lock_q;
   assign HWDATA_MASTER    = wdata_q;
   assign TIMEOUT_FLAG     = flag_q;
   assign DBG_STATE        = state_q;

endmodule

// File: tb/tb_ahb_slv2mst_reg_bridge.sv
// Directed bench for ahb_slv2mst_reg_bridge.
// Instance u0 has no remap and an 8-cycle timeout.
// Instance u1 remaps the top nibble to 4'hA and has the timeout disabled.
// Both instances share the same stimulus.
// Inputs are driven and outputs are sampled 1 time unit after the rising edge.
module tb_ahb_slv2mst_reg_bridge;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL_SLAVE;
  logic [31:0] HADDR_SLAVE;
  logic [1:0]  HTRANS_SLAVE;
  logic [2:0]  HSIZE_SLAVE;
  logic [2:0]  HBURST_SLAVE;
  logic [3:0]  HPROT_SLAVE;
  logic        HWRITE_SLAVE;
  logic        HMASTLOCK_SLAVE;
  logic [31:0] HWDATA_SLAVE;
  logic        HREADY_SLAVE;
  logic        HREADY_MASTER;
  logic [31:0] HRDATA_MASTER;
  logic [1:0]  HRESP_MASTER;

  logic        rdy_0, rdy_1;
  logic [31:0] rdata_0, rdata_1;
  logic [1:0]  resp_0, resp_1;
  logic [31:0] maddr_0, maddr_1;
  logic [1:0]  mtrans_0, mtrans_1;
  logic [2:0]  msize_0, msize_1;
  logic [2:0]  mburst_0, mburst_1;
  logic [3:0]  mprot_0, mprot_1;
  logic        mwrite_0, mwrite_1;
  logic        mlock_0, mlock_1;
  logic [31:0] mwdata_0, mwdata_1;
  logic        tflag_0, tflag_1;
  logic [2:0]  st_0, st_1;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 HCLK = ~HCLK;

  ahb_slv2mst_reg_bridge #(.TIMEOUT_CYCLES(8)) u0 (
    .HCLK(HCLK), .HRESET(HRESET),
    .HSEL_SLAVE(HSEL_SLAVE), .HADDR_SLAVE(HADDR_SLAVE), .HTRANS_SLAVE(HTRANS_SLAVE),
    .HSIZE_SLAVE(HSIZE_SLAVE), .HBURST_SLAVE(HBURST_SLAVE), .HPROT_SLAVE(HPROT_SLAVE),
    .HWRITE_SLAVE(HWRITE_SLAVE), .HMASTLOCK_SLAVE(HMASTLOCK_SLAVE),
    .HWDATA_SLAVE(HWDATA_SLAVE), .HREADY_SLAVE(HREADY_SLAVE),
    .HREADYOUT_SLAVE(rdy_0), .HRDATA_SLAVE(rdata_0), .HRESP_SLAVE(resp_0),
    .HADDR_MASTER(maddr_0), .HTRANS_MASTER(mtrans_0), .HSIZE_MASTER(msize_0),
    .HBURST_MASTER(mburst_0), .HPROT_MASTER(mprot_0), .HWRITE_MASTER(mwrite_0),
    .HMASTLOCK_MASTER(mlock_0), .HWDATA_MASTER(mwdata_0),
    .HREADY_MASTER(HREADY_MASTER), .HRDATA_MASTER(HRDATA_MASTER), .HRESP_MASTER(HRESP_MASTER),
    .TIMEOUT_FLAG(tflag_0), .DBG_STATE(st_0)
  );

  ahb_slv2mst_reg_bridge #(.REMAP_EN(1), .REMAP_BITS(4), .REMAP_VALUE(4'hA)) u1 (
    .HCLK(HCLK), .HRESET(HRESET),
    .HSEL_SLAVE(HSEL_SLAVE), .HADDR_SLAVE(HADDR_SLAVE), .HTRANS_SLAVE(HTRANS_SLAVE),
    .HSIZE_SLAVE(HSIZE_SLAVE), .HBURST_SLAVE(HBURST_SLAVE), .HPROT_SLAVE(HPROT_SLAVE),
    .HWRITE_SLAVE(HWRITE_SLAVE), .HMASTLOCK_SLAVE(HMASTLOCK_SLAVE),
    .HWDATA_SLAVE(HWDATA_SLAVE), .HREADY_SLAVE(HREADY_SLAVE),
    .HREADYOUT_SLAVE(rdy_1), .HRDATA_SLAVE(rdata_1), .HRESP_SLAVE(resp_1),
    .HADDR_MASTER(maddr_1), .HTRANS_MASTER(mtrans_1), .HSIZE_MASTER(msize_1),
    .HBURST_MASTER(mburst_1), .HPROT_MASTER(mprot_1), .HWRITE_MASTER(mwrite_1),
    .HMASTLOCK_MASTER(mlock_1), .HWDATA_MASTER(mwdata_1),
    .HREADY_MASTER(HREADY_MASTER), .HRDATA_MASTER(HRDATA_MASTER), .HRESP_MASTER(HRESP_MASTER),
    .TIMEOUT_FLAG(tflag_1), .DBG_STATE(st_1)
  );

  // driver tasks
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic wr, input logic [1:0] trans);
    HSEL_SLAVE   = 1'b1;
    HADDR_SLAVE  = addr;
    HWRITE_SLAVE = wr;
    HTRANS_SLAVE = trans;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    step();
    step();
    checks++; if (rdy_0 !== 1'b1) begin errors++; $display("FAIL reset_hreadyout: got %b expected 1", rdy_0); end
    checks++; if (mtrans_0 !== 2'b00) begin errors++; $display("FAIL reset_htrans: got %b expected 00", mtrans_0); end
    checks++; if (resp_0 !== 2'b00) begin errors++; $display("FAIL reset_hresp: got %b expected 00", resp_0); end
    checks++; if (rdata_0 !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %h expected 0", rdata_0); end
    checks++; if (maddr_0 !== 32'h0) begin errors++; $display("FAIL reset_haddr: got %h expected 0", maddr_0); end
    checks++; if (tflag_0 !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b expected 0", tflag_0); end
    checks++; if (st_0 !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", st_0); end
    HRESET = 1'b0;
    step();
  endtask

  task automatic test_single_write();
    drive_req(32'h2000_0010, 1'b1, 2'b10);   // cycle T
    HSIZE_SLAVE = 3'd2;
    HPROT_SLAVE = 4'b0011;
    HREADY_MASTER = 1'b1;
    step();                                   // T+1: downstream address phase
    checks++; if (maddr_0 !== 32'h2000_0010) begin errors++; $display("FAIL wr_haddr: got %h expected 20000010", maddr_0); end
    checks++; if (mtrans_0 !== 2'b10) begin errors++; $display("FAIL wr_htrans_nonseq: got %b expected 10", mtrans_0); end
    checks++; if (mwrite_0 !== 1'b1) begin errors++; $display("FAIL wr_hwrite: got %b expected 1", mwrite_0); end
    checks++; if (msize_0 !== 3'd2 || mprot_0 !== 4'b0011) begin errors++; $display("FAIL wr_ctrl: got size %0d prot %b expected 2 0011", msize_0, mprot_0); end
    checks++; if (rdy_0 !== 1'b0) begin errors++; $display("FAIL wr_stall1: got %b expected 0", rdy_0); end
    HWDATA_SLAVE = 32'hDEAD_BEEF;
    HTRANS_SLAVE = 2'b00;
    step();                                   // T+2: downstream data phase
    checks++; if (mwdata_0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_hwdata: got %h expected deadbeef", mwdata_0); end
    checks++; if (mtrans_0 !== 2'b00) begin errors++; $display("FAIL wr_htrans_idle: got %b expected 00", mtrans_0); end
    checks++; if (rdy_0 !== 1'b0) begin errors++; $display("FAIL wr_stall2: got %b expected 0", rdy_0); end
    step();                                   // T+3: upstream response
    checks++; if (rdy_0 !== 1'b1 || resp_0 !== 2'b00) begin errors++; $display("FAIL wr_done: got rdy %b resp %b expected 1 00", rdy_0, resp_0); end
    step();
    checks++; if (st_0 !== 3'd0) begin errors++; $display("FAIL wr_back_idle: got %0d expected 0", st_0); end
  endtask

  task automatic test_remap_read();
    drive_req(32'h3000_0040, 1'b0, 2'b10);   // T
    HREADY_MASTER = 1'b1;
    step();                                   // T+1
    checks++; if (maddr_1 !== 32'hA000_0040) begin errors++; $display("FAIL remap_haddr: got %h expected a0000040", maddr_1); end
    checks++; if (maddr_0 !== 32'h3000_0040) begin errors++; $display("FAIL noremap_haddr: got %h expected 30000040", maddr_0); end
    HTRANS_SLAVE = 2'b00;
    step();                                   // T+2: first wait state
    HREADY_MASTER = 1'b0;
    step();                                   // T+3: second wait state
    checks++; if (rdy_1 !== 1'b0) begin errors++; $display("FAIL remap_wait: got %b expected 0", rdy_1); end
    step();                                   // T+4: downstream completes
    HREADY_MASTER = 1'b1;
    HRDATA_MASTER = 32'h1234_5678;
    step();                                   // T+5
    checks++; if (rdy_1 !== 1'b1 || rdata_1 !== 32'h1234_5678) begin errors++; $display("FAIL remap_rdata: got rdy %b data %h expected 1 12345678", rdy_1, rdata_1); end
    HRDATA_MASTER = 32'h0;
    step();
    checks++; if (rdata_1 !== 32'h0) begin errors++; $display("FAIL rdata_clears: got %h expected 0", rdata_1); end
  endtask

  task automatic test_error();
    drive_req(32'h2000_0020, 1'b1, 2'b10);
    HREADY_MASTER = 1'b1;
    step();                                   // ADDR
    HTRANS_SLAVE = 2'b00;
    step();                                   // DATA, first ERROR cycle
    HREADY_MASTER = 1'b0;
    HRESP_MASTER  = 2'b01;
    step();                                   // ERR1
    checks++; if (rdy_0 !== 1'b0 || resp_0 !== 2'b01) begin errors++; $display("FAIL err1: got rdy %b resp %b expected 0 01", rdy_0, resp_0); end
    HREADY_MASTER = 1'b1;
    step();                                   // ERR2
    checks++; if (rdy_0 !== 1'b1 || resp_0 !== 2'b01) begin errors++; $display("FAIL err2: got rdy %b resp %b expected 1 01", rdy_0, resp_0); end
    HRESP_MASTER = 2'b00;
    step();
    checks++; if (resp_0 !== 2'b00 || st_0 !== 3'd0) begin errors++; $display("FAIL err_recover: got resp %b state %0d expected 00 0", resp_0, st_0); end
    // the next transfer completes OKAY
    drive_req(32'h2000_0030, 1'b0, 2'b10);
    step();
    HTRANS_SLAVE = 2'b00;
    step();
    HRDATA_MASTER = 32'hCAFE_F00D;
    step();
    checks++; if (rdy_0 !== 1'b1 || resp_0 !== 2'b00 || rdata_0 !== 32'hCAFE_F00D) begin errors++; $display("FAIL err_next_ok: got rdy %b resp %b data %h expected 1 00 cafef00d", rdy_0, resp_0, rdata_0); end
    HRDATA_MASTER = 32'h0;
    step();
  endtask

  task automatic test_timeout();
    drive_req(32'h2000_0040, 1'b1, 2'b10);   // T
    HREADY_MASTER = 1'b0;
    step();                                   // T+1
    HTRANS_SLAVE = 2'b00;
    for (int i = 2; i <= 8; i++) step();      // T+8: last ADDR cycle
    checks++; if (rdy_0 !== 1'b0 || mtrans_0 !== 2'b10 || tflag_0 !== 1'b0) begin errors++; $display("FAIL to_before: got rdy %b trans %b flag %b expected 0 10 0", rdy_0, mtrans_0, tflag_0); end
    step();                                   // T+9: ERR1
    checks++; if (tflag_0 !== 1'b1) begin errors++; $display("FAIL to_flag: got %b expected 1", tflag_0); end
    checks++; if (mtrans_0 !== 2'b00) begin errors++; $display("FAIL to_htrans_idle: got %b expected 00", mtrans_0); end
    checks++; if (rdy_0 !== 1'b0 || resp_0 !== 2'b01) begin errors++; $display("FAIL to_err1: got rdy %b resp %b expected 0 01", rdy_0, resp_0); end
    step();                                   // T+10: ERR2
    checks++; if (rdy_0 !== 1'b1 || resp_0 !== 2'b01) begin errors++; $display("FAIL to_err2: got rdy %b resp %b expected 1 01", rdy_0, resp_0); end
    // a late downstream response must not produce another upstream response
    HREADY_MASTER = 1'b1;
    step();
    step();
    checks++; if (tflag_0 !== 1'b1 || st_0 !== 3'd0 || resp_0 !== 2'b00) begin errors++; $display("FAIL to_sticky: got flag %b state %0d resp %b expected 1 0 00", tflag_0, st_0, resp_0); end
    checks++; if (tflag_1 !== 1'b0) begin errors++; $display("FAIL to_disabled: got %b expected 0", tflag_1); end
    step();
  endtask

  task automatic test_reset_mid_transfer();
    drive_req(32'h2000_0050, 1'b1, 2'b10);
    HREADY_MASTER = 1'b1;
    step();                                   // ADDR
    HTRANS_SLAVE = 2'b00;
    HWDATA_SLAVE = 32'h5555_AAAA;
    step();                                   // DATA
    HREADY_MASTER = 1'b0;
    #2;
    HRESET = 1'b1;
    #1;
    checks++; if (rdy_0 !== 1'b1 || mtrans_0 !== 2'b00 || tflag_0 !== 1'b0) begin errors++; $display("FAIL rst_async: got rdy %b trans %b flag %b expected 1 00 0", rdy_0, mtrans_0, tflag_0); end
    checks++; if (st_0 !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", st_0); end
    step();
    HRESET = 1'b0;
    HREADY_MASTER = 1'b1;
    step();
    drive_req(32'h2000_0060, 1'b1, 2'b10);
    step();
    HTRANS_SLAVE = 2'b00;
    HWDATA_SLAVE = 32'h0BAD_F00D;
    step();
    checks++; if (mwdata_0 !== 32'h0BAD_F00D) begin errors++; $display("FAIL rst_next_wdata: got %h expected 0badf00d", mwdata_0); end
    step();
    checks++; if (rdy_0 !== 1'b1 || resp_0 !== 2'b00) begin errors++; $display("FAIL rst_next_done: got rdy %b resp %b expected 1 00", rdy_0, resp_0); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] wd [4];
    logic [31:0] base;
    logic [31:0] got;
    wd[0] = 32'h1111_0000; wd[1] = 32'h2222_0004; wd[2] = 32'h3333_0008; wd[3] = 32'h4444_000C;
    base = 32'h4000_0100;
    HREADY_MASTER = 1'b1;
    HBURST_SLAVE  = 3'b011;                   // INCR4
    drive_req(base, 1'b1, 2'b10);
    for (int i = 0; i < 4; i++) begin
      step();                                 // ADDR of beat i
      checks++; if (maddr_0 !== base + 32'(4 * i) || mtrans_0 !== 2'b10 || mburst_0 !== 3'b000) begin errors++; $display("FAIL b2b_addr%0d: got %h trans %b burst %b expected %h 10 000", i, maddr_0, mtrans_0, mburst_0, base + 32'(4 * i)); end
      HWDATA_SLAVE = wd[i];
      exp_q.push_back(wd[i]);
      if (i < 3) drive_req(base + 32'(4 * (i + 1)), 1'b1, 2'b11);
      else HTRANS_SLAVE = 2'b00;
      step();                                 // DATA of beat i
      got = exp_q.pop_front();
      checks++; if (mwdata_0 !== got || mtrans_0 !== 2'b00) begin errors++; $display("FAIL b2b_data%0d: got %h trans %b expected %h 00", i, mwdata_0, mtrans_0, got); end
      step();                                 // RESP of beat i, next beat accepted
      checks++; if (rdy_0 !== 1'b1 || resp_0 !== 2'b00) begin errors++; $display("FAIL b2b_resp%0d: got rdy %b resp %b expected 1 00", i, rdy_0, resp_0); end
    end
    step();
    checks++; if (st_0 !== 3'd0 || mtrans_0 !== 2'b00) begin errors++; $display("FAIL b2b_end: got state %0d trans %b expected 0 00", st_0, mtrans_0); end
    HBURST_SLAVE = 3'b000;
  endtask

  initial begin
    HRESET = 1'b1;
    HSEL_SLAVE = 1'b0; HADDR_SLAVE = '0; HTRANS_SLAVE = 2'b00; HSIZE_SLAVE = 3'd2;
    HBURST_SLAVE = 3'b000; HPROT_SLAVE = 4'b0011; HWRITE_SLAVE = 1'b0;
    HMASTLOCK_SLAVE = 1'b0; HWDATA_SLAVE = '0; HREADY_SLAVE = 1'b1;
    HREADY_MASTER = 1'b1; HRDATA_MASTER = '0; HRESP_MASTER = 2'b00;
    test_reset();
    test_single_write();
    test_remap_read();
    test_error();
    test_timeout();
    test_reset_mid_transfer();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
